// File: rtl/life_pkg.sv
// Shared types and width helpers for the cell-grid readout path.
package life_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int GRID_W    = 8;
    localparam int GRID_H    = 8;
    localparam int ROW_IDX_W = $clog2(GRID_H);
    localparam int POP_W     = $clog2(GRID_W * GRID_H + 1);

    // A single-row grid still needs a one-bit row index port.
    function automatic int row_idx_width(input int h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

    function automatic int pop_width(input int cells);
        return $clog2(cells + 1);
    endfunction

endpackage

// File: rtl/row_popcount.sv
// Combinational population count of one row word.
module row_popcount #(
    parameter int W = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/grid_readout.sv
// Snapshots the cell grid on each generation tick and streams it out row by row,
// tracking the generation count and the population of the last drained frame.
module grid_readout
    import life_pkg::*;
#(
    parameter int W     = 8,
    parameter int H     = 8,
    parameter int GEN_W = 16,
    localparam int RW   = row_idx_width(H),
    localparam int PW   = pop_width(W * H),
    localparam int CW   = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic [W*H-1:0]   grid,
    input  logic             gen_tick,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [RW-1:0]    out_row,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done,
    output logic [GEN_W-1:0] gen_count,
    output logic [PW-1:0]    pop_count,
    output logic             overrun
);

    state_t state;
    state_t state_next;

    logic [W*H-1:0] snap;
    logic [RW-1:0]  row;
    logic [PW-1:0]  acc;
    logic [CW-1:0]  row_pop;
    logic           xfer;
    logic           last_xfer;
    logic           capture;
    logic           row_is_last;

    assign row_is_last = (row == RW'(H - 1));
    assign xfer        = (state == SEND) && out_ready;
    assign last_xfer   = xfer && row_is_last;
    // A tick landing on the final transfer starts the next frame with no idle gap.
    assign capture     = gen_tick && ((state == IDLE) || last_xfer);

    assign out_data  = snap[int'(row) * W +: W];
    assign out_row   = row;
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = (state == SEND) && row_is_last;

    row_popcount #(.W(W)) u_row_popcount (
        .bits  (out_data),
        .count (row_pop)
    );

    always_ff @(posedge clk) begin
        if (!_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (gen_tick) state_next = SEND;
            SEND: if (last_xfer && !gen_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            snap       <= '0;
            row        <= '0;
            acc        <= '0;
            gen_count  <= '0;
            pop_count  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= last_xfer;
            if (last_xfer) begin
                pop_count <= acc + PW'(row_pop);
            end
            if (capture) begin
                snap      <= grid;
                row       <= '0;
                acc       <= '0;
                gen_count <= gen_count + GEN_W'(1);
            end else if (xfer) begin
                acc <= acc + PW'(row_pop);
                if (!row_is_last) begin
                    row <= row + RW'(1);
                end
            end
            if (gen_tick && (state == SEND) && !last_xfer) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grid_readout.sv
// Scoreboard bench for grid_readout: directed frames with hand-computed rows and populations.
module tb_grid_readout;

    typedef struct {
        logic [7:0] data;
        logic [2:0] row;
        logic       last;
    } exp_t;

    localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
    localparam logic [63:0] DIAG   = 64'h8040_2010_0804_0201;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gen_tick;
    logic        out_ready;
    logic [63:0] grid;

    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_row;
    logic        out_last;
    logic        busy;
    logic        frame_done;
    logic [15:0] gen_count;
    logic [6:0]  pop_count;
    logic        overrun;

    logic        tick2;
    logic        ready2;
    logic [15:0] grid2;
    logic        v2;
    logic [7:0]  d2;
    logic [0:0]  r2;
    logic        l2;
    logic        b2;
    logic        fd2;
    logic [7:0]  g2;
    logic [4:0]  p2;
    logic        o2;

    exp_t sb[$];
    int   checks   = 0;
    int   fails    = 0;
    int   fd_count = 0;
    logic prev_stall = 1'b0;
    logic [7:0] held_data;
    logic [2:0] held_row;

    always #5 clk = ~clk;

    grid_readout #(.W(8), .H(8), .GEN_W(16)) dut (
        .clk        (clk),
        ._rst       (rst_n),
        .grid       (grid),
        .gen_tick   (gen_tick),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done),
        .gen_count  (gen_count),
        .pop_count  (pop_count),
        .overrun    (overrun)
    );

    // Short, narrow-counter instance so generation wrap is reachable quickly.
    grid_readout #(.W(8), .H(2), .GEN_W(8)) dut_wrap (
        .clk        (clk),
        ._rst       (rst_n),
        .grid       (grid2),
        .gen_tick   (tick2),
        .out_ready  (ready2),
        .out_valid  (v2),
        .out_data   (d2),
        .out_row    (r2),
        .out_last   (l2),
        .busy       (b2),
        .frame_done (fd2),
        .gen_count  (g2),
        .pop_count  (p2),
        .overrun    (o2)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic tick, input logic rdy, input logic [63:0] g);
        @(posedge clk);
        #1;
        rst_n     = rst;
        gen_tick  = tick;
        out_ready = rdy;
        grid      = g;
    endtask

    task automatic pushFrame(input logic [63:0] g);
        for (int r = 0; r < 8; r++) begin
            exp_t e;
            e.data = g[r*8 +: 8];
            e.row  = 3'(r);
            e.last = (r == 7);
            sb.push_back(e);
        end
    endtask

    task automatic waitFrameDone(output int cyc);
        cyc = 0;
        while (!frame_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!frame_done) checkOutput("frame_done timeout", {63'd0, frame_done}, 64'd1);
    endtask

    task automatic waitRow(input logic [2:0] r);
        int n = 0;
        while (!(out_valid && out_row == r) && n < 40) begin
            applyStimulus(1'b1, 1'b0, 1'b1, grid);
            n++;
        end
        checkOutput("reach row", {61'd0, out_row}, {61'd0, r});
    endtask

    // Monitor: pops the scoreboard on every accepted row and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                checkOutput("stall valid held", {63'd0, out_valid}, 64'd1);
                checkOutput("stall data held", {56'd0, out_data}, {56'd0, held_data});
                checkOutput("stall row held", {61'd0, out_row}, {61'd0, held_row});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected row: got row %0d data 0x%0h, expected none", out_row, out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("row data", {56'd0, out_data}, {56'd0, e.data});
                    checkOutput("row index", {61'd0, out_row}, {61'd0, e.row});
                    checkOutput("row last", {63'd0, out_last}, {63'd0, e.last});
                end
            end
            if (frame_done) fd_count++;
            prev_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_row   = out_row;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int fd_before;
        rst_n     = 1'b0;
        gen_tick  = 1'b0;
        out_ready = 1'b1;
        grid      = '0;
        tick2     = 1'b0;
        ready2    = 1'b1;
        grid2     = 16'hFFFF;
        repeat (2) @(posedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1, '0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, '0);
            checkOutput("idle after reset",
                {out_valid, out_row, out_last, busy, frame_done, gen_count, pop_count, overrun}, 64'd0);
        end

        // Glider frame, ready held high.
        applyStimulus(1'b1, 1'b1, 1'b1, GLIDER);
        pushFrame(GLIDER);
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        checkOutput("first valid", {63'd0, out_valid}, 64'd1);
        checkOutput("first row", {61'd0, out_row}, 64'd0);
        waitFrameDone(cyc);
        checkOutput("frame cycles", 64'(cyc), 64'd9);
        checkOutput("glider pop", {57'd0, pop_count}, 64'd5);
        checkOutput("glider gen", {48'd0, gen_count}, 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        checkOutput("frame_done single", {63'd0, frame_done}, 64'd0);
        checkOutput("done count 1", 64'(fd_count), 64'd1);
        checkOutput("scoreboard empty 1", 64'(sb.size()), 64'd0);

        // Backpressure: ready pattern 1,0,0,1.
        applyStimulus(1'b1, 1'b1, 1'b1, GLIDER);
        pushFrame(GLIDER);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 1'b0, (i % 4 == 0) || (i % 4 == 3), GLIDER);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        checkOutput("bp done count", 64'(fd_count), 64'd2);
        checkOutput("bp pop", {57'd0, pop_count}, 64'd5);
        checkOutput("bp gen", {48'd0, gen_count}, 64'd2);
        checkOutput("scoreboard empty 2", 64'(sb.size()), 64'd0);

        // Tick coincident with the final transfer chains straight into the next frame.
        applyStimulus(1'b1, 1'b1, 1'b1, GLIDER);
        pushFrame(GLIDER);
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        waitRow(3'd7);
        gen_tick = 1'b1;
        grid     = DIAG;
        pushFrame(DIAG);
        applyStimulus(1'b1, 1'b0, 1'b1, DIAG);
        checkOutput("chain valid", {63'd0, out_valid}, 64'd1);
        checkOutput("chain row", {61'd0, out_row}, 64'd0);
        checkOutput("chain gen", {48'd0, gen_count}, 64'd4);
        checkOutput("chain frame_done", {63'd0, frame_done}, 64'd1);
        checkOutput("chain pop", {57'd0, pop_count}, 64'd5);
        checkOutput("chain overrun", {63'd0, overrun}, 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, DIAG);
        waitFrameDone(cyc);
        checkOutput("diag pop", {57'd0, pop_count}, 64'd8);
        checkOutput("diag gen", {48'd0, gen_count}, 64'd4);

        // Ticks at rows 2 and 5 are dropped; grid changes then must not leak in.
        applyStimulus(1'b1, 1'b1, 1'b1, GLIDER);
        pushFrame(GLIDER);
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        waitRow(3'd2);
        gen_tick = 1'b1;
        grid     = ONES;
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        checkOutput("overrun set", {63'd0, overrun}, 64'd1);
        checkOutput("overrun gen", {48'd0, gen_count}, 64'd5);
        waitRow(3'd5);
        gen_tick = 1'b1;
        grid     = ONES;
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        waitFrameDone(cyc);
        checkOutput("overrun frame gen", {48'd0, gen_count}, 64'd5);
        checkOutput("overrun frame pop", {57'd0, pop_count}, 64'd5);
        checkOutput("overrun sticky", {63'd0, overrun}, 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        checkOutput("done count 5", 64'(fd_count), 64'd5);
        checkOutput("scoreboard empty 3", 64'(sb.size()), 64'd0);

        // Reset during row 3 discards the frame.
        applyStimulus(1'b1, 1'b1, 1'b1, GLIDER);
        pushFrame(GLIDER);
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        waitRow(3'd3);
        rst_n     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        checkOutput("mid-frame reset",
            {out_valid, out_row, out_last, busy, frame_done, gen_count, pop_count, overrun}, 64'd0);
        sb.delete();
        fd_before = fd_count;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        checkOutput("no done after reset", 64'(fd_count), 64'(fd_before));
        applyStimulus(1'b1, 1'b1, 1'b1, GLIDER);
        pushFrame(GLIDER);
        applyStimulus(1'b1, 1'b0, 1'b1, GLIDER);
        checkOutput("restart row", {61'd0, out_row}, 64'd0);
        waitFrameDone(cyc);
        checkOutput("restart gen", {48'd0, gen_count}, 64'd1);
        checkOutput("restart pop", {57'd0, pop_count}, 64'd5);

        // Full grid.
        applyStimulus(1'b1, 1'b1, 1'b1, ONES);
        pushFrame(ONES);
        applyStimulus(1'b1, 1'b0, 1'b1, ONES);
        waitFrameDone(cyc);
        checkOutput("ones pop", {57'd0, pop_count}, 64'd64);
        checkOutput("ones gen", {48'd0, gen_count}, 64'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, ONES);
        checkOutput("scoreboard empty 4", 64'(sb.size()), 64'd0);

        // Generation counter wrap on the 8-bit instance.
        for (int i = 0; i < 255; i++) begin
            @(posedge clk); #1 tick2 = 1'b1;
            @(posedge clk); #1 tick2 = 1'b0;
            repeat (3) @(posedge clk);
        end
        #1;
        checkOutput("wrap gen max", {56'd0, g2}, 64'd255);
        checkOutput("wrap pop", {59'd0, p2}, 64'd16);
        @(posedge clk); #1 tick2 = 1'b1;
        @(posedge clk); #1 tick2 = 1'b0;
        checkOutput("wrap gen zero", {56'd0, g2}, 64'd0);
        checkOutput("wrap first row", {54'd0, v2, r2, d2}, {54'd0, 1'b1, 1'b0, 8'hFF});
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wrap idle flags", {59'd0, v2, b2, l2, fd2, o2}, 64'd0);

        checkOutput("total frames done", 64'(fd_count), 64'd7);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
